// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and transaction sequencer in front of sram_controller.
// It issues one command at a time, routes read data back to the issuing port, and aborts stalled commands.
module sram_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        owner,
    output logic        active,
    output logic [15:0] ctl_addr,
    output logic [15:0] ctl_wdata,
    output logic        ctl_wr,
    output logic        ctl_rd,
    input  logic [15:0] ctl_rdata,
    input  logic        ctl_valid,
    input  logic        ctl_busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic        wr_q, wr_d, rd_q, rd_d;
    logic        active_q, active_d;
    logic        grant;
    logic        grant_we;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        grant    = 1'b0;
        grant_we = 1'b0;

        case (state_q)
            StIdle: begin
                if (!ctl_busy && (req0 || req1)) begin
                    // On a tie the port that was not served last wins.
                    grant    = (req0 && req1) ? ~last_q : req1;
                    grant_we = grant ? we1 : we0;
                    owner_d  = grant;
                    we_d     = grant_we;
                    addr_d   = grant ? addr1 : addr0;
                    wdata_d  = grant ? wdata1 : wdata0;
                    wr_d     = grant_we;
                    rd_d     = ~grant_we;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (ctl_valid) begin
                    if (!we_q) begin
                        if (owner_q) rdata1_d = ctl_rdata;
                        else         rdata0_d = ctl_rdata;
                    end
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TimeoutVal) begin
                        err0_d  = ~owner_q;
                        err1_d  = owner_q;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        active_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            active_q <= active_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign owner     = owner_q;
    assign active    = active_q;
    assign ctl_addr  = addr_q;
    assign ctl_wdata = wdata_q;
    assign ctl_wr    = wr_q;
    assign ctl_rd    = rd_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: expected strobes and completions are queued at stimulus time
// and popped when the DUT shows them; a small controller model answers commands.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic        owner, active;
    logic [15:0] ctl_addr, ctl_wdata;
    logic        ctl_wr, ctl_rd;
    logic [15:0] ctl_rdata;
    logic        ctl_valid;
    logic        ctl_busy;

    sram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1), .owner(owner), .active(active),
        .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_wr(ctl_wr), .ctl_rd(ctl_rd),
        .ctl_rdata(ctl_rdata), .ctl_valid(ctl_valid), .ctl_busy(ctl_busy)
    );

    always #2 clk = ~clk;

    typedef struct packed {logic wr; logic rd; logic [15:0] addr; logic [15:0] wdata;} strobe_t;
    typedef struct packed {logic [3:0] flags; logic [15:0] rd0; logic [15:0] rd1;} done_t;

    strobe_t     sq[$];
    done_t       dq[$];
    logic [15:0] exp_rd[2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_dly, valid_at, spur_at, strobe_cyc, done_cyc, c0, t1;
    bit pending, done_seen, hold0, hold1, r_is_rd;
    logic [15:0] r_addr;

    task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] resp_data(input logic [15:0] a);
        return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    // One clock: observe outputs, then drive the controller model and requester reactions.
    task automatic tick();
        strobe_t es;
        done_t   ed;
        @(posedge clk);
        #1;
        cyc++;
        if (ctl_wr || ctl_rd) begin
            strobe_cyc = cyc;
            if (sq.size() > 0) begin
                es = sq.pop_front();
                check_eq("strobe", {ctl_wr, ctl_rd, ctl_addr, ctl_wdata}, es);
            end else begin
                check_eq("unexp_strobe", {ctl_wr, ctl_rd}, 2'b00);
            end
            if (resp_dly > 0) begin
                pending  = 1'b1;
                valid_at = cyc + resp_dly;
                r_is_rd  = ctl_rd;
                r_addr   = ctl_addr;
            end
        end
        if (ack0 || ack1 || err0 || err1) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            if (dq.size() > 0) begin
                ed = dq.pop_front();
                check_eq("done", {ack0, ack1, err0, err1, rdata0, rdata1}, ed);
            end else begin
                check_eq("unexp_done", {ack0, ack1, err0, err1}, 4'b0000);
            end
            if ((ack0 || err0) && !hold0) req0 = 1'b0;
            if ((ack1 || err1) && !hold1) req1 = 1'b0;
        end
        ctl_valid = 1'b0;
        if (pending && cyc == valid_at) begin
            ctl_valid = 1'b1;
            ctl_rdata = r_is_rd ? resp_data(r_addr) : 16'hFFFF;
            pending   = 1'b0;
        end else if (cyc == spur_at) begin
            ctl_valid = 1'b1;
            ctl_rdata = 16'hDEAD;
        end
    endtask

    task automatic drive(input bit p, input logic we, input logic [15:0] a, input logic [15:0] d);
        if (!p) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else    begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    endtask

    task automatic push_strobe(input logic we, input logic [15:0] a, input logic [15:0] d);
        sq.push_back({we, ~we, a, d});
    endtask

    task automatic push_done(input bit p, input bit is_err, input bit is_rd, input logic [15:0] a);
        done_t e;
        if (!is_err && is_rd) exp_rd[p] = resp_data(a);
        e.flags = {!p && !is_err, p && !is_err, !p && is_err, p && is_err};
        e.rd0   = exp_rd[0];
        e.rd1   = exp_rd[1];
        dq.push_back(e);
    endtask

    task automatic wait_done(input int max);
        done_seen = 1'b0;
        for (int n = 0; n < max && !done_seen; n++) tick();
        check_eq("wait_done", {35'd0, done_seen}, 36'd1);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        hold0   = 1'b0;
        hold1   = 1'b0;
        pending = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        ctl_rdata = '0; ctl_valid = 1'b0; ctl_busy = 1'b0;
        resp_dly = 1; valid_at = -1; spur_at = -1; strobe_cyc = 0; done_cyc = 0;
        pending = 1'b0; done_seen = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
        r_is_rd = 1'b0; r_addr = '0; exp_rd[0] = '0; exp_rd[1] = '0;

        #5;
        check_eq("rst_ctrl", {ack0, ack1, err0, err1, ctl_wr, ctl_rd, active, owner}, 36'd0);
        check_eq("rst_rdata", {rdata0, rdata1}, 36'd0);
        check_eq("rst_ctl_bus", {ctl_addr, ctl_wdata}, 36'd0);
        do_reset();

        // Single read, controller answers two cycles after the strobe.
        resp_dly = 2; c0 = cyc;
        drive(0, 1'b0, 16'h1234, 16'h0BAD);
        push_strobe(1'b0, 16'h1234, 16'h0BAD);
        push_done(0, 1'b0, 1'b1, 16'h1234);
        wait_done(20);
        check_eq("rd_strobe_cyc", 36'(strobe_cyc - c0), 36'd1);
        check_eq("rd_latency", 36'(done_cyc - c0), 36'd4);
        tick();

        // Fastest write on port 1.
        resp_dly = 1; c0 = cyc;
        drive(1, 1'b1, 16'h0077, 16'h1357);
        push_strobe(1'b1, 16'h0077, 16'h1357);
        push_done(1, 1'b0, 1'b0, 16'h0077);
        wait_done(20);
        check_eq("min_latency", 36'(done_cyc - c0), 36'd3);
        tick();

        // Both ports hold write requests after reset: 0, 1, 0.
        do_reset();
        hold0 = 1'b1; hold1 = 1'b1; resp_dly = 1;
        drive(0, 1'b1, 16'h0010, 16'hAAAA);
        drive(1, 1'b1, 16'h0020, 16'h5555);
        push_strobe(1'b1, 16'h0010, 16'hAAAA);
        push_strobe(1'b1, 16'h0020, 16'h5555);
        push_strobe(1'b1, 16'h0010, 16'hAAAA);
        push_done(0, 1'b0, 1'b0, 16'h0010);
        push_done(1, 1'b0, 1'b0, 16'h0020);
        push_done(0, 1'b0, 1'b0, 16'h0010);
        wait_done(20);
        t1 = done_cyc;
        wait_done(20);
        check_eq("b2b_period", 36'(done_cyc - t1), 36'd4);
        wait_done(20);
        req0 = 1'b0; req1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
        tick();

        // Busy controller holds the request off.
        ctl_busy = 1'b1;
        drive(1, 1'b0, 16'h0042, 16'h0000);
        push_strobe(1'b0, 16'h0042, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("busy_idle", {active, ctl_wr, ctl_rd}, 36'd0);
        end
        ctl_busy = 1'b0; c0 = cyc;
        push_done(1, 1'b0, 1'b1, 16'h0042);
        wait_done(20);
        check_eq("busy_strobe_cyc", 36'(strobe_cyc - c0), 36'd1);
        tick();

        // Controller never answers: error after TIMEOUT wait cycles, rdata1 kept.
        resp_dly = 0; c0 = cyc;
        drive(1, 1'b0, 16'h0099, 16'h0000);
        push_strobe(1'b0, 16'h0099, 16'h0000);
        push_done(1, 1'b1, 1'b1, 16'h0099);
        wait_done(30);
        check_eq("timeout_latency", 36'(done_cyc - c0), 36'(2 + TIMEOUT));
        tick();
        resp_dly = 1;
        drive(1, 1'b0, 16'h00AA, 16'h0000);
        push_strobe(1'b0, 16'h00AA, 16'h0000);
        push_done(1, 1'b0, 1'b1, 16'h00AA);
        wait_done(20);
        tick();

        // Answer in the last wait cycle still counts as success.
        resp_dly = TIMEOUT; c0 = cyc;
        drive(0, 1'b0, 16'h0055, 16'h0000);
        push_strobe(1'b0, 16'h0055, 16'h0000);
        push_done(0, 1'b0, 1'b1, 16'h0055);
        wait_done(30);
        check_eq("edge_latency", 36'(done_cyc - c0), 36'(2 + TIMEOUT));
        tick();

        // Stray ctl_valid while idle.
        spur_at = cyc + 2;
        repeat (5) tick();
        spur_at = -1;
        check_eq("spur_rdata", {rdata0, rdata1}, {4'd0, exp_rd[0], exp_rd[1]});

        // Reset in the middle of WAIT.
        resp_dly = 0;
        drive(0, 1'b0, 16'h0123, 16'h0000);
        push_strobe(1'b0, 16'h0123, 16'h0000);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ctrl", {ack0, ack1, err0, err1, ctl_wr, ctl_rd, active, owner}, 36'd0);
        check_eq("rst_mid_data", {rdata0, rdata1}, 36'd0);
        check_eq("rst_mid_bus", {ctl_addr, ctl_wdata}, 36'd0);
        req0 = 1'b0; pending = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0;
        tick();
        rst_n = 1'b1;
        repeat (TIMEOUT + 6) tick();

        // First tie after reset goes to port 0.
        resp_dly = 1;
        drive(0, 1'b0, 16'h0300, 16'h0000);
        drive(1, 1'b0, 16'h0301, 16'h0000);
        push_strobe(1'b0, 16'h0300, 16'h0000);
        push_strobe(1'b0, 16'h0301, 16'h0000);
        push_done(0, 1'b0, 1'b1, 16'h0300);
        push_done(1, 1'b0, 1'b1, 16'h0301);
        wait_done(20);
        wait_done(20);
        repeat (3) tick();

        check_eq("strobes_left", 36'(sq.size()), 36'd0);
        check_eq("dones_left", 36'(dq.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter and transaction sequencer in front of `sram_controller`. It replaces fixed-priority steering with a request/acknowledge handshake per requester, so each requester gets fair access. Each read response returns only to the port that issued the read. A watchdog terminates transactions the controller never completes. Requesters are the bus-interface logic on one side; the single `sram_controller` instance is on the other.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum WAIT cycles before a transaction is aborted (range 1..255).

Ports:
- `clk`  in  1: system clock, 250 MHz.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req0` / `req1`  in  1: port request; held high until `ackN` or `errN`.
- `we0` / `we1`  in  1: 1 = write, 0 = read; stable while `reqN` is high.
- `addr0` / `addr1`  in  16: word address; stable while `reqN` is high.
- `wdata0` / `wdata1`  in  16: write data; stable while `reqN` is high.
- `ack0` / `ack1`  out  1: one-cycle completion pulse.
- `err0` / `err1`  out  1: one-cycle timeout pulse.
- `rdata0` / `rdata1`  out  16: read data; valid with `ackN` and held until the next read completes on that port.
- `owner`  out  1: port currently granted; meaningful while `active` is high.
- `active`  out  1: high in ISSUE, WAIT and DONE.
- `ctl_addr`  out  16: address to the controller.
- `ctl_wdata`  out  16: write data to the controller.
- `ctl_wr` / `ctl_rd`  out  1: one-cycle command strobes to the controller.
- `ctl_rdata`  in  16: read data from the controller.
- `ctl_valid`  in  1: one-cycle completion pulse from the controller, for reads and writes.
- `ctl_busy`  in  1: controller cannot accept a command.

## Operation
- State machine has four states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- **IDLE**
  - Leaves only when `ctl_busy`=0 and at least one of `req0`/`req1` is high.
  - A single requester is granted.
  - If both request, the port that is not `last` is granted.
  - On grant: latch `owner`, `addr`, `wdata`, `we`; go to ISSUE.
- **ISSUE**
  - `ctl_wr`=`we` or `ctl_rd`=!`we`, high for exactly this cycle.
  - `ctl_addr` and `ctl_wdata` carry the latched values.
  - Clear the watchdog counter; go to WAIT.
- **WAIT**
  - On `ctl_valid`: if read, capture `ctl_rdata` into `rdataN` of the owner; go to DONE with the success flag set.
  - Otherwise the counter increments. When it reaches `TIMEOUT`, go to DONE with the error flag set.
  - `ctl_valid` in the same cycle the counter hits `TIMEOUT` counts as success.
- **DONE**
  - `ackN` (success) or `errN` (timeout) of the owner is high for this cycle only.
  - Set `last` = `owner`; go to IDLE.
- DONE exists so that `reqN` in the following IDLE cycle already reflects the requester's reaction to the ack. A requester that holds `req` high after its ack is treated as issuing a new request.
- `ctl_addr` and `ctl_wdata` hold their last values outside ISSUE. `ctl_wr` and `ctl_rd` are 0 outside ISSUE.
- `ctl_valid` outside WAIT is ignored.
- A timeout does not modify `rdataN`.
- The non-owner port's `rdata` is never modified.

## Timing
- Reset values:
  - State IDLE, `last`=1 (port 0 wins the first tie).
  - Counter 0.
  - All `ack`/`err`/`ctl_wr`/`ctl_rd`/`active`/`owner` = 0.
  - `rdata0`, `rdata1`, `ctl_addr`, `ctl_wdata` = 0.
- Cycle-level latency, with `req` sampled high in IDLE at cycle 0:
  - ISSUE is cycle 1 (strobe).
  - WAIT starts at cycle 2.
  - If `ctl_valid` is sampled at cycle V, ack is at cycle V+1.
  - Minimum `req`→`ack` is 3 cycles (`ctl_valid` at cycle 2).
- Back-to-back throughput: next IDLE is at V+2, so the best-case period is 4 cycles per transaction.
- `ctl_busy` high holds the arbiter in IDLE indefinitely with no strobe issued.
- Timeout: with no `ctl_valid`, err is at cycle 2+`TIMEOUT`.
- Reset mid-transaction: immediate return to reset values with no ack/err emitted. The controller shares `rst_n`.

## Test plan
- **Single read:** `req0`=1, `we0`=0, `addr0`=0x1234; `ctl_valid` with `ctl_rdata`=0xBEEF two cycles after the strobe → `ctl_rd` pulse with `ctl_addr`=0x1234; `ack0` 1 cycle; `rdata0`=0xBEEF; `rdata1` unchanged at 0.
- **Simultaneous requests after reset:** both ports write (0x0010←0xAAAA, 0x0020←0x5555), held high → port 0 served first, then port 1, then port 0 again; `ctl_wr` sequence carries addresses 0x0010, 0x0020, 0x0010.
- **Busy hold:** `ctl_busy`=1 for 10 cycles with `req1`=1 → no strobe during those cycles; strobe in the cycle after `ctl_busy` falls + 1.
- **Timeout:** `TIMEOUT`=4, read on port 1, `ctl_valid` never asserted → `err1` at cycle 6 after `req`; no `ack1`; `rdata1` unchanged; next request is served normally.
- **Boundary:** `ctl_valid` coincident with the counter reaching `TIMEOUT` → `ack`, not `err`. Spurious `ctl_valid` in IDLE → no ack and no `rdata` change.
- **Reset mid-WAIT:** assert `rst_n`=0 during WAIT → all outputs at reset values asynchronously; no ack after release; port 0 wins the next tie.
